// File: rtl/ttl_74593_seq.sv
// Strobe sequencer for one 74593 counter/register (INC, LOAD, CLEAR, OE commands).
// Optional macro CNT_SHADOW_CHECK_EN: shadow count compared with q_in; a mismatch sets sticky err.
module ttl_74593_seq #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned PULSE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_bar,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             cmd_ready,
  output logic             done,
  output logic             wrap,
  output logic             err,
  output logic             CCK,
  output logic             RCK,
  output logic             CCKEN,
  output logic             CCKEN_bar,
  output logic             RCKEN_bar,
  output logic             CLOAD_bar,
  output logic             CCLR_bar,
  output logic             G,
  output logic             G_bar,
  output logic [WIDTH-1:0] d_out,
  input  logic             rco_bar,
  input  logic [WIDTH-1:0] q_in
);

  localparam int unsigned MAX_CYC = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, RELEASE, DONE} state_t;
  typedef enum logic [1:0] {OP_INC = 2'b00, OP_LOAD = 2'b01, OP_CLEAR = 2'b10, OP_OE = 2'b11} op_t;

  state_t          state, state_n;
  op_t             op, op_n;
  logic            ld_phase, ld_phase_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            wrap_pend, wrap_pend_n;
  logic            g_n;
  logic [WIDTH-1:0] d_n;
  logic            in_seq;
  logic            cck_n, rck_n, ccken_n, rcken_bar_n, cload_bar_n, cclr_bar_n;

  // Strobes are decoded from the next state and registered, so pins never glitch.
  always_comb begin
    state_n     = state;
    op_n        = op;
    ld_phase_n  = ld_phase;
    cnt_n       = cnt;
    wrap_pend_n = wrap_pend;
    g_n         = G;
    d_n         = d_out;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          op_n        = op_t'(cmd_op);
          ld_phase_n  = 1'b0;
          wrap_pend_n = !rco_bar && G;
          cnt_n       = SETUP_LAST;
          state_n     = SETUP;
          if (op_t'(cmd_op) == OP_OE) begin
            g_n     = cmd_data[0];
            state_n = DONE;
          end
          if (op_t'(cmd_op) == OP_LOAD) d_n = cmd_data;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = ACTIVE;
          cnt_n   = PULSE_LAST;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ACTIVE: begin
        if (cnt == '0) state_n = RELEASE;
        else           cnt_n   = cnt - 1'b1;
      end
      RELEASE: begin
        // LOAD runs the RCK sub-sequence first, then replays the phases for CLOAD_bar.
        if (op == OP_LOAD && !ld_phase) begin
          ld_phase_n = 1'b1;
          cnt_n      = SETUP_LAST;
          state_n    = SETUP;
        end else begin
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    in_seq      = (state_n == SETUP) || (state_n == ACTIVE) || (state_n == RELEASE);
    cck_n       = (state_n == ACTIVE) && (op_n == OP_INC || op_n == OP_CLEAR);
    rck_n       = (state_n == ACTIVE) && (op_n == OP_LOAD) && !ld_phase_n;
    ccken_n     = in_seq && (op_n == OP_INC);
    rcken_bar_n = !(in_seq && (op_n == OP_LOAD) && !ld_phase_n);
    cload_bar_n = !(((state_n == SETUP) || (state_n == ACTIVE)) && (op_n == OP_LOAD) && ld_phase_n);
    cclr_bar_n  = !(in_seq && (op_n == OP_CLEAR));
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state     <= IDLE;
      op        <= OP_INC;
      ld_phase  <= 1'b0;
      cnt       <= '0;
      wrap_pend <= 1'b0;
      CCK       <= 1'b0;
      RCK       <= 1'b0;
      CCKEN     <= 1'b0;
      CCKEN_bar <= 1'b1;
      RCKEN_bar <= 1'b1;
      CLOAD_bar <= 1'b1;
      CCLR_bar  <= 1'b1;
      G         <= 1'b0;
      G_bar     <= 1'b1;
      d_out     <= '0;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_n;
      op        <= op_n;
      ld_phase  <= ld_phase_n;
      cnt       <= cnt_n;
      wrap_pend <= wrap_pend_n;
      CCK       <= cck_n;
      RCK       <= rck_n;
      CCKEN     <= ccken_n;
      CCKEN_bar <= !ccken_n;
      RCKEN_bar <= rcken_bar_n;
      CLOAD_bar <= cload_bar_n;
      CCLR_bar  <= cclr_bar_n;
      G         <= g_n;
      G_bar     <= !g_n;
      d_out     <= d_n;
      cmd_ready <= (state_n == IDLE);
      done      <= (state_n == DONE);
      wrap      <= (state_n == DONE) && (op_n == OP_INC) && wrap_pend_n;
    end
  end

`ifdef CNT_SHADOW_CHECK_EN
  logic [WIDTH-1:0] shadow;
  logic             finishing;

  assign finishing = (state == RELEASE) && (state_n == DONE);

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      shadow <= '0;
      err    <= 1'b0;
    end else begin
      if (finishing) begin
        case (op)
          OP_INC:   shadow <= shadow + 1'b1;
          OP_LOAD:  shadow <= d_out;
          OP_CLEAR: shadow <= '0;
          default:  ;
        endcase
      end
      if (finishing && op == OP_CLEAR)               err <= 1'b0;
      else if (state == IDLE && G && q_in != shadow) err <= 1'b1;
    end
  end
`else
  logic unused_q;
  assign unused_q = ^q_in;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_ttl_74593_seq.sv
// Self-checking bench for ttl_74593_seq: per-command expected pin traces plus a 74593 chip model.
module tb_ttl_74593_seq;
  localparam int unsigned W  = 8;
  localparam int          S  = 1;
  localparam int          P  = 1;
  localparam int          VW = 12 + W;
  localparam logic [VW-1:0] RESET_VEC = 20'h83D00;
`ifdef CNT_SHADOW_CHECK_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_bar = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [1:0]   cmd_op = '0;
  logic [W-1:0] cmd_data = '0;
  logic cmd_ready, done, wrap, err, CCK, RCK, CCKEN, CCKEN_bar, RCKEN_bar, CLOAD_bar, CCLR_bar, G, G_bar;
  logic [W-1:0] d_out;
  logic         rco_bar;
  logic [W-1:0] q_in;

  logic [W-1:0] chip_cnt = '0, chip_reg = '0;
  logic         q_force = 1'b0;
  logic [W-1:0] q_force_val = '0;
  assign q_in    = q_force ? q_force_val : chip_cnt;
  assign rco_bar = !(chip_cnt == '1);

  always #5 clk = ~clk;

  ttl_74593_seq #(.WIDTH(W), .SETUP_CYCLES(S), .PULSE_CYCLES(P)) dut (
    .clk(clk), .reset_bar(reset_bar), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .done(done), .wrap(wrap), .err(err), .CCK(CCK), .RCK(RCK),
    .CCKEN(CCKEN), .CCKEN_bar(CCKEN_bar), .RCKEN_bar(RCKEN_bar), .CLOAD_bar(CLOAD_bar),
    .CCLR_bar(CCLR_bar), .G(G), .G_bar(G_bar), .d_out(d_out), .rco_bar(rco_bar), .q_in(q_in)
  );

  // External 74593 behaviour driven by the strobes.
  int   cck_rises = 0, rck_rises = 0, cload_rises = 0;
  logic cck_d = 1'b0, rck_d = 1'b0, cload_d = 1'b1;
  always @(CCK or RCK or CLOAD_bar) begin
    if (RCK && !rck_d) begin
      rck_rises++;
      if (!RCKEN_bar) chip_reg = d_out;
    end
    if (CCK && !cck_d) begin
      cck_rises++;
      if (!CCLR_bar)  chip_cnt = '0;
      else if (CCKEN) chip_cnt = chip_cnt + 1'b1;
    end
    if (CLOAD_bar && !cload_d) begin
      cload_rises++;
      chip_cnt = chip_reg;
    end
    rck_d = RCK; cck_d = CCK; cload_d = CLOAD_bar;
  end

  typedef struct {
    bit ready, done, wrap, cck, rck, ccken, rcken_n, cload_n, cclr_n, g;
    logic [W-1:0] d;
    int kind;   // 1 INC, 2 LOAD, 3 CLEAR completes when this cycle begins
  } vec_t;

  vec_t         cur;
  vec_t         tq[$];
  bit           g_m, err_m, known_m;
  logic [W-1:0] d_m, shadow_m;
  int checks = 0, errors = 0, cyc = 0;
  int done_seen = 0, wrap_seen = 0, cck_en_seen = 0;
  int done_cycs[$];

  function automatic vec_t base_vec();
    vec_t v;
    v.ready = 0; v.done = 0; v.wrap = 0; v.cck = 0; v.rck = 0; v.ccken = 0;
    v.rcken_n = 1; v.cload_n = 1; v.cclr_n = 1; v.g = g_m; v.d = d_m; v.kind = 0;
    return v;
  endfunction

  task automatic push(vec_t v, int n);
    for (int i = 0; i < n; i++) tq.push_back(v);
  endtask

  task automatic build(logic [1:0] op, logic [W-1:0] data, bit wr);
    vec_t v;
    if (op == 2'd3) g_m = data[0];
    if (op == 2'd1) d_m = data;
    v = base_vec();
    case (op)
      2'd0: begin v.ccken = 1; push(v, S); v.cck = 1; push(v, P); v.cck = 0; push(v, 1); end
      2'd1: begin
        v.rcken_n = 0; push(v, S); v.rck = 1; push(v, P); v.rck = 0; push(v, 1);
        v = base_vec(); v.cload_n = 0; push(v, S + P); v.cload_n = 1; push(v, 1);
      end
      2'd2: begin v.cclr_n = 0; push(v, S); v.cck = 1; push(v, P); v.cck = 0; push(v, 1); end
      default: ;
    endcase
    v = base_vec();
    v.done = 1;
    v.wrap = (op == 2'd0) && wr;
    v.kind = (op == 2'd3) ? 0 : int'(op) + 1;
    push(v, 1);
  endtask

  task automatic reset_model();
    tq.delete();
    g_m = 0; d_m = '0; shadow_m = '0; err_m = 0; known_m = 0;
    cur = base_vec(); cur.ready = 1;
  endtask

  task automatic model_edge();
    if (cur.ready) begin
      if (SHADOW && cur.g && q_in != shadow_m) err_m = 1;
      if (cmd_valid) build(cmd_op, cmd_data, !rco_bar && cur.g);
    end
    if (tq.size() > 0) cur = tq.pop_front();
    else begin cur = base_vec(); cur.ready = 1; end
    case (cur.kind)
      1: shadow_m = shadow_m + 1'b1;
      2: begin shadow_m = cur.d; known_m = 1; end
      3: begin shadow_m = '0; err_m = 0; known_m = 1; end
      default: ;
    endcase
  endtask

  function automatic logic [VW-1:0] exp_vec(vec_t v);
    return {v.ready, v.done, v.wrap, v.cck, v.rck, v.ccken, !v.ccken, v.rcken_n,
            v.cload_n, v.cclr_n, v.g, !v.g, v.d};
  endfunction

  function automatic logic [VW-1:0] act_vec();
    return {cmd_ready, done, wrap, CCK, RCK, CCKEN, CCKEN_bar, RCKEN_bar,
            CLOAD_bar, CCLR_bar, G, G_bar, d_out};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
    end
  endtask

  task automatic compare_cycle();
    check("pins", 32'(act_vec()), 32'(exp_vec(cur)));
    check("err", 32'(err), 32'(err_m));
    check("cck_rck_overlap", 32'(CCK && RCK), 32'd0);
    check("clr_during_rck", 32'(RCK && !CCLR_bar), 32'd0);
    if (known_m && cur.ready) check("counter_q", 32'(chip_cnt), 32'(shadow_m));
    if (done) begin done_seen++; done_cycs.push_back(cyc); end
    if (wrap) wrap_seen++;
    if (CCK && CCKEN && !CCLR_bar) cck_en_seen++;
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
    cyc++;
    compare_cycle();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cur.ready && n < 64) begin tick(); n++; end
    if (!cur.ready) begin errors++; $display("FAIL wait_idle: still busy after %0d cycles", n); end
  endtask

  task automatic do_cmd(logic [1:0] op, logic [W-1:0] data);
    wait_idle();
    cmd_valid = 1; cmd_op = op; cmd_data = data;
    tick();
    cmd_valid = 0; cmd_op = 2'($urandom_range(0, 3)); cmd_data = W'($urandom);
    wait_idle();
  endtask

  task automatic check_reset(string name);
    check(name, 32'(act_vec()), 32'(RESET_VEC));
    check({name, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [W-1:0] qv[$];
    reset_bar = 0;
    repeat (3) @(negedge clk);
    check_reset("reset_state");
    reset_model();
    reset_bar = 1;

    // LOAD 0xA5 then OE 1
    done_seen = 0; rck_rises = 0; cload_rises = 0;
    do_cmd(2'd1, 8'hA5);
    check("load_rck_rises", 32'(rck_rises), 32'd1);
    check("load_cload_rises", 32'(cload_rises), 32'd1);
    do_cmd(2'd3, 8'h01);
    check("load_q", 32'(chip_cnt), 32'hA5);
    check("load_oe_dones", 32'(done_seen), 32'd2);
    check("oe_g", 32'(G), 32'd1);

    // LOAD 0xFF, INC wraps
    do_cmd(2'd1, 8'hFF);
    cck_rises = 0; wrap_seen = 0;
    do_cmd(2'd0, 8'h00);
    check("inc_wrap_q", 32'(chip_cnt), 32'h00);
    check("inc_cck_rises", 32'(cck_rises), 32'd1);
    check("inc_wrap_seen", 32'(wrap_seen), 32'd1);

    // CLEAR after LOAD 0x3C
    do_cmd(2'd1, 8'h3C);
    check("load3c_q", 32'(chip_cnt), 32'h3C);
    rck_rises = 0; cck_en_seen = 0;
    do_cmd(2'd2, 8'h00);
    check("clear_q", 32'(chip_cnt), 32'h00);
    check("clear_rck_rises", 32'(rck_rises), 32'd0);
    check("clear_cck_with_en", 32'(cck_en_seen), 32'd0);

    // back-to-back INC with cmd_valid held
    wait_idle();
    done_cycs.delete(); done_seen = 0;
    cmd_valid = 1; cmd_op = 2'd0;
    n = 0;
    while (done_seen < 3 && n < 40) begin
      tick(); n++;
      if (done) qv.push_back(chip_cnt);
    end
    cmd_valid = 0;
    wait_idle();
    if (done_cycs.size() >= 3 && qv.size() >= 3) begin
      check("b2b_q1", 32'(qv[0]), 32'd1);
      check("b2b_q2", 32'(qv[1]), 32'd2);
      check("b2b_q3", 32'(qv[2]), 32'd3);
      check("b2b_spacing1", 32'(done_cycs[1] - done_cycs[0]), 32'd5);
      check("b2b_spacing2", 32'(done_cycs[2] - done_cycs[1]), 32'd5);
    end else begin
      errors++;
      $display("FAIL b2b_dones: got %0d dones, expected 3", done_cycs.size());
    end

`ifdef CNT_SHADOW_CHECK_EN
    do_cmd(2'd1, 8'h10);
    q_force_val = 8'h12; q_force = 1;
    tick(); tick();
    check("shadow_err_set", 32'(err), 32'd1);
    q_force = 0;
    tick();
    check("shadow_err_sticky", 32'(err), 32'd1);
    do_cmd(2'd2, 8'h00);
    check("shadow_err_cleared", 32'(err), 32'd0);
`endif

    // randomized commands, including input changes while busy
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_data  = ($urandom_range(0, 3) == 0) ? '1 : W'($urandom);
      if (SHADOW && $urandom_range(0, 24) == 0) begin
        q_force = ~q_force;
        q_force_val = W'($urandom);
      end
      tick();
    end
    cmd_valid = 0; q_force = 0;
    wait_idle();

    // reset during the RCK pulse of a LOAD
    cmd_valid = 1; cmd_op = 2'd1; cmd_data = 8'h5A;
    tick();
    cmd_valid = 0;
    n = 0;
    while (!cur.rck && n < 10) begin tick(); n++; end
    check("midload_rck_high", 32'(RCK), 32'd1);
    #2 reset_bar = 0;
    #1 check_reset("midload_reset");
    reset_model();
    @(negedge clk);
    reset_bar = 1;
    do_cmd(2'd2, 8'h00);
    check("post_reset_clear_q", 32'(chip_cnt), 32'h00);
    do_cmd(2'd3, 8'h01);
    do_cmd(2'd0, 8'h00);
    check("post_reset_inc_q", 32'(chip_cnt), 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
